// File: rtl/risc_mc.sv
// rtl/risc_mc.sv - parametrised multi-cycle RISC core (IF/RF/EX/MEM/WB) with memory wait-state handshake
// Optional: define RISC_MUL_EN to make ALU op 7 an unsigned DW-bit multiply.
module risc_mc #(
    parameter int DW      = 16,
    parameter int AW      = 16,
    parameter int NREG    = 8,
    parameter int PC_STEP = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          mem_ready,
    output logic [DW-1:0] dout,
    output logic [AW-1:0] addr,
    output logic          oe,
    output logic          we,
    output logic          retire
);

    localparam int RIW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int OW  = (AW > 16) ? AW : 16;

    typedef enum logic [2:0] {S_IF, S_RF, S_EX, S_MEM, S_WB} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] pc;
    logic [15:0]   ir;
    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] a_val, b_val, mdr;

    logic [RIW-1:0] rd_idx, rs_idx;
    logic           is_jmp, is_br, is_imm, is_mem, is_ld;
    logic [3:0]     alu_op;
    logic [DW-1:0]  imm_sext, alu_b, alu_y;
    logic [OW-1:0]  jmp_ext, br_ext;
    logic [AW-1:0]  jmp_off, br_off;
    logic           br_taken;

    // Register fields are taken modulo NREG by keeping only the low index bits.
    assign rd_idx   = ir[8 +: RIW];
    assign rs_idx   = ir[5 +: RIW];
    assign is_jmp   = ir[15] & ir[14];
    assign is_br    = ir[15] & ~ir[14];
    assign is_imm   = ~ir[15] & (ir[14:11] != 4'h0);
    assign is_mem   = (ir[15:11] == 5'h0) & ir[4];
    assign is_ld    = is_mem & ir[0];
    assign alu_op   = is_imm ? ir[14:11] : ir[3:0];
    assign imm_sext = {{(DW-8){ir[7]}}, ir[7:0]};
    assign alu_b    = is_imm ? imm_sext : b_val;
    assign jmp_ext  = {{(OW-11){ir[10]}}, ir[10:0]};
    assign br_ext   = {{(OW-8){ir[7]}}, ir[7:0]};
    assign jmp_off  = jmp_ext[AW-1:0];
    assign br_off   = br_ext[AW-1:0];

    always_comb begin
        br_taken = 1'b0;
        case (ir[12:11])
            2'b00: br_taken = (a_val != '0);
            2'b01: br_taken = (a_val == '0);
            2'b10: br_taken = a_val[DW-1];
            2'b11: br_taken = ~a_val[DW-1];
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        alu_y = '0;
        case (alu_op)
            4'h0: alu_y = a_val;
            4'h1: alu_y = alu_b;
            4'h2: alu_y = ~alu_b;
            4'h3: alu_y = a_val ^ alu_b;
            4'h4: alu_y = a_val + alu_b;
            4'h5: alu_y = a_val - alu_b;
            4'h6: alu_y = alu_b << 8;
`ifdef RISC_MUL_EN
            4'h7: alu_y = a_val * alu_b;
`else
            4'h7: alu_y = '0;
`endif
            4'h8: alu_y = alu_b << 1;
            4'h9: alu_y = alu_b >> 1;
            4'hA: alu_y = a_val & alu_b;
            4'hB: alu_y = a_val | alu_b;
            default: alu_y = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IF;
        else     state <= state_nx;
    end

    // Bus outputs are forced quiet while reset is held, whatever the state register says.
    always_comb begin
        state_nx = state;
        addr     = '0;
        oe       = 1'b0;
        we       = 1'b0;
        dout     = '0;
        retire   = 1'b0;
        if (!rst) begin
            case (state)
                S_IF: begin
                    addr = pc;
                    oe   = 1'b1;
                    if (mem_ready) state_nx = S_RF;
                end
                S_RF: state_nx = S_EX;
                S_EX: begin
                    if (is_mem) begin
                        state_nx = S_MEM;
                    end else begin
                        retire   = 1'b1;
                        state_nx = S_IF;
                    end
                end
                S_MEM: begin
                    addr = AW'(b_val);
                    if (is_ld) begin
                        oe = 1'b1;
                    end else begin
                        we   = 1'b1;
                        dout = a_val;
                    end
                    if (mem_ready) begin
                        if (is_ld) begin
                            state_nx = S_WB;
                        end else begin
                            retire   = 1'b1;
                            state_nx = S_IF;
                        end
                    end
                end
                S_WB: begin
                    retire   = 1'b1;
                    state_nx = S_IF;
                end
                default: state_nx = S_IF;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            ir    <= '0;
            a_val <= '0;
            b_val <= '0;
            mdr   <= '0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            case (state)
                S_IF: begin
                    if (mem_ready) begin
                        ir <= din[15:0];
                        pc <= pc + AW'(PC_STEP);
                    end
                end
                S_RF: begin
                    a_val <= regs[rd_idx];
                    b_val <= regs[rs_idx];
                end
                // pc already holds the incremented fetch address here.
                S_EX: begin
                    if (is_jmp) begin
                        pc <= pc + jmp_off;
                    end else if (is_br) begin
                        if (br_taken) pc <= pc + br_off;
                    end else if (!is_mem) begin
                        regs[rd_idx] <= alu_y;
                    end
                end
                S_MEM: begin
                    if (mem_ready && is_ld) mdr <= din;
                end
                S_WB: regs[rd_idx] <= mdr;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_risc_mc.sv
// tb/tb_risc_mc.sv - scoreboard bench for risc_mc: expected bus accesses and retires queued, monitor compares
module tb_risc_mc;

    localparam int RD  = 0;
    localparam int WR  = 1;
    localparam int RET = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1 = 1'b1, rst2 = 1'b1, rdy = 1'b1, sel = 1'b0;
    logic [15:0] din1, dout1, addr1;
    logic        oe1, we1, ret1;
    logic [31:0] din2, dout2;
    logic [7:0]  addr2;
    logic        oe2, we2, ret2;
    logic [31:0] mem [256];

    assign din1 = mem[addr1[7:0]][15:0];
    assign din2 = mem[addr2];

    risc_mc dut1 (
        .clk(clk), .rst(rst1), .din(din1), .mem_ready(rdy),
        .dout(dout1), .addr(addr1), .oe(oe1), .we(we1), .retire(ret1)
    );

    risc_mc #(.DW(32), .AW(8)) dut2 (
        .clk(clk), .rst(rst2), .din(din2), .mem_ready(rdy),
        .dout(dout2), .addr(addr2), .oe(oe2), .we(we2), .retire(ret2)
    );

    typedef struct {
        int          kind;
        int          cyc;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    always @(posedge clk) begin
        if (sel ? rst2 : rst1) cyc <= 0;
        else                   cyc <= cyc + 1;
    end

    logic [31:0] b_addr, b_dout;
    logic        b_oe, b_we, b_ret, b_rst;
    always_comb begin
        b_addr = sel ? {24'h0, addr2} : {16'h0, addr1};
        b_dout = sel ? dout2 : {16'h0, dout1};
        b_oe   = sel ? oe2 : oe1;
        b_we   = sel ? we2 : we1;
        b_ret  = sel ? ret2 : ret1;
        b_rst  = sel ? rst2 : rst1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t cyc=%0d)", name, act, req, $time, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k; e.cyc = c; e.a = a; e.d = d;
        q.push_back(e);
    endtask

    initial begin : monitor
        ev_t         e;
        logic        prev_stall;
        logic [49:0] prev_bus;
        prev_stall = 1'b0;
        prev_bus   = '0;
        forever begin
            @(negedge clk);
            if (rst1) chk("reset_out1", {oe1, we1, ret1, addr1, dout1}, 0);
            if (rst2) chk("reset_out2", {oe2, we2, ret2, addr2, dout2}, 0);
            if (!b_rst) begin
                chk("oe_we_exclusive", b_oe & b_we, 0);
                if ((b_oe | b_we) && !rdy) begin
                    if (prev_stall) chk("stall_stable", {b_oe, b_we, b_addr[15:0], b_dout}, prev_bus);
                    prev_stall = 1'b1;
                    prev_bus   = {b_oe, b_we, b_addr[15:0], b_dout};
                end else begin
                    prev_stall = 1'b0;
                end
                if ((b_oe | b_we) && rdy) begin
                    if (q.size() == 0) begin
                        chk("unexpected_access", q.size(), 1);
                    end else begin
                        e = q.pop_front();
                        chk("access_kind", b_we ? 1 : 0, e.kind);
                        chk("access_addr", b_addr, e.a);
                        if (b_we) chk("store_data", b_dout, e.d);
                        if (e.cyc >= 0) chk("access_cycle", cyc, e.cyc);
                    end
                end
                if (b_ret) begin
                    if (q.size() == 0) begin
                        chk("unexpected_retire", q.size(), 1);
                    end else begin
                        e = q.pop_front();
                        chk("retire_kind", RET, e.kind);
                        if (e.cyc >= 0) chk("retire_cycle", cyc, e.cyc);
                    end
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic begin_run(input logic s);
        sel = s;
        repeat (2) @(posedge clk);
        #1;
        if (s) rst2 = 1'b0;
        else   rst1 = 1'b0;
    endtask

    task automatic finish_run(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(posedge clk);
        chk("drain", q.size(), 0);
        q.delete();
        #1;
        rst1 = 1'b1;
        rst2 = 1'b1;
        rdy  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic alu_i(input int pc);
        push(RD, -1, pc, 0);
        push(RET, -1, 0, 0);
    endtask

    task automatic st_i(input int pc, input logic [31:0] a, input logic [31:0] d);
        push(RD, -1, pc, 0);
        push(WR, -1, a, d);
        push(RET, -1, 0, 0);
    endtask

    task automatic mul_prog(input logic [31:0] res);
        clear_mem();
        mem[0] = 32'h3101; mem[2] = 32'h3203; mem[4] = 32'h0147;
        mem[6] = 32'h0B60; mem[8] = 32'h0170;
        push(RD, 0, 0, 0);  push(RET, 2, 0, 0);
        push(RD, 3, 2, 0);  push(RET, 5, 0, 0);
        push(RD, 6, 4, 0);  push(RET, 8, 0, 0);
        push(RD, 9, 6, 0);  push(RET, 11, 0, 0);
        push(RD, 12, 8, 0); push(WR, 15, 32'h60, res); push(RET, 15, 0, 0);
        push(RD, 16, 10, 0);
    endtask

    initial begin : stimulus
        logic [31:0] mul32;
`ifdef RISC_MUL_EN
        mul32 = 32'h0003_0000;
`else
        mul32 = 32'h0;
`endif
        clear_mem();
        repeat (3) @(posedge clk);
        #1;

        // add-immediate, second immediate, store of r1
        clear_mem();
        mem[0] = 32'h2105; mem[2] = 32'h2240; mem[4] = 32'h0150;
        push(RD, 0, 0, 0);  push(RET, 2, 0, 0);
        push(RD, 3, 2, 0);  push(RET, 5, 0, 0);
        push(RD, 6, 4, 0);  push(WR, 9, 32'h40, 32'h5); push(RET, 9, 0, 0);
        push(RD, 10, 6, 0);
        begin_run(0);
        finish_run(40);

        // three wait states on the first fetch, then LD r1 <- mem[r1]
        clear_mem();
        mem[0] = 32'h0131; mem[2] = 32'h2250; mem[4] = 32'h0150;
        push(RD, 3, 0, 0);  push(RD, 6, 0, 0); push(RET, 7, 0, 0);
        push(RD, 8, 2, 0);  push(RET, 10, 0, 0);
        push(RD, 11, 4, 0); push(WR, 14, 32'h50, 32'h0131); push(RET, 14, 0, 0);
        push(RD, 15, 6, 0);
        rdy = 1'b0;
        begin_run(0);
        repeat (3) @(posedge clk);
        #1 rdy = 1'b1;
        finish_run(40);

        // r2=0xBEEF, r1=0x40, stalled store, then a repeat store proving registers unchanged
        clear_mem();
        mem[0] = 32'h32BF; mem[2] = 32'h22EF; mem[4] = 32'h0940;
        mem[6] = 32'h0230; mem[8] = 32'h0230;
        push(RD, 0, 0, 0);  push(RET, 2, 0, 0);
        push(RD, 3, 2, 0);  push(RET, 5, 0, 0);
        push(RD, 6, 4, 0);  push(RET, 8, 0, 0);
        push(RD, 9, 6, 0);  push(WR, 14, 32'h40, 32'hBEEF); push(RET, 14, 0, 0);
        push(RD, 15, 8, 0); push(WR, 18, 32'h40, 32'hBEEF); push(RET, 18, 0, 0);
        push(RD, 19, 10, 0);
        begin_run(0);
        repeat (12) @(posedge clk);
        #1 rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1 rdy = 1'b1;
        finish_run(40);

        // BEQZ taken, BNEZ not taken, JMP -2 self-loop
        clear_mem();
        mem[0] = 32'h8904; mem[6] = 32'h8108; mem[8] = 32'hC7FE;
        push(RD, 0, 0, 0);  push(RET, 2, 0, 0);
        push(RD, 3, 6, 0);  push(RET, 5, 0, 0);
        push(RD, 6, 8, 0);  push(RET, 8, 0, 0);
        push(RD, 9, 8, 0);  push(RET, 11, 0, 0);
        push(RD, 12, 8, 0);
        begin_run(0);
        finish_run(40);

        // BNEZ at pc 0 falls to pc 2, BLTZ not taken, BGEZ -6 back to 0
        clear_mem();
        mem[0] = 32'h8108; mem[2] = 32'h9104; mem[4] = 32'h99FA;
        push(RD, 0, 0, 0); push(RET, 2, 0, 0);
        push(RD, 3, 2, 0); push(RET, 5, 0, 0);
        push(RD, 6, 4, 0); push(RET, 8, 0, 0);
        push(RD, 9, 0, 0);
        begin_run(0);
        finish_run(40);

        // JMP -2 at pc 0 loops to 0
        clear_mem();
        mem[0] = 32'hC7FE;
        push(RD, 0, 0, 0); push(RET, 2, 0, 0);
        push(RD, 3, 0, 0); push(RET, 5, 0, 0);
        push(RD, 6, 0, 0);
        begin_run(0);
        finish_run(40);

        // ALU op sweep, results observed through stores to 0x40
        clear_mem();
        mem[0]  = 32'h2105; mem[2]  = 32'h0A40; mem[4]  = 32'h2903; mem[6]  = 32'h0128;
        mem[8]  = 32'h19FF; mem[10] = 32'h0129; mem[12] = 32'h0150; mem[14] = 32'h510F;
        mem[16] = 32'h014B; mem[18] = 32'h0322; mem[20] = 32'h0350; mem[22] = 32'h010C;
        mem[24] = 32'h0150;
        for (int pc = 0; pc < 12; pc += 2) alu_i(pc);
        st_i(12, 32'h40, 32'h7FFD);
        alu_i(14); alu_i(16); alu_i(18);
        st_i(20, 32'h40, 32'hFFB2);
        alu_i(22);
        st_i(24, 32'h40, 32'h0000);
        begin_run(0);
        finish_run(100);

        // reset during a stalled store: no write, restart fetch at 0
        clear_mem();
        mem[0] = 32'h0230;
        push(RD, 0, 0, 0);
        begin_run(0);
        repeat (3) @(posedge clk);
        #1 rdy = 1'b0;
        @(posedge clk);
        #1 rst1 = 1'b1;
        rdy = 1'b1;
        push(RD, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst1 = 1'b0;
        finish_run(20);

        // multiply op 7: DW=16 low product bits are zero either way; DW=32 depends on RISC_MUL_EN
        mul_prog(32'h0);
        begin_run(0);
        finish_run(40);
        mul_prog(mul32);
        begin_run(1);
        finish_run(40);

        // AW=8 pc wrap: JMP -4 to 0xFE, then JMP +4 wraps through 0x00 to 0x04
        clear_mem();
        mem[0] = 32'hC7FC; mem[8'hFE] = 32'hC004;
        push(RD, 0, 0, 0);     push(RET, 2, 0, 0);
        push(RD, 3, 8'hFE, 0); push(RET, 5, 0, 0);
        push(RD, 6, 4, 0);
        begin_run(1);
        finish_run(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
